// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester handshakes and the shared RAM port.
// The arbiter uses the slave view; the requesters/RAM side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;

  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [1:0]        lsu_be;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              gpu_req;
  logic              gpu_urgent;
  logic [ADDR_W-1:0] gpu_addr;
  logic              gpu_gnt;
  logic              gpu_rvalid;
  logic [DATA_W-1:0] gpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    input  gpu_req, gpu_urgent, gpu_addr,
    output gpu_gnt, gpu_rvalid, gpu_rdata,
    output mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    output gpu_req, gpu_urgent, gpu_addr,
    input  gpu_gnt, gpu_rvalid, gpu_rdata,
    input  mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single-port program/data RAM: GPU urgent override,
// fetch anti-starvation override, then round-robin; read data tagged one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_async,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LSU   = 2'd2,
    OWN_GPU   = 2'd3
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // rr_ptr_reg holds the last-granted requester; GPU at reset makes fetch first.
  owner_t     rr_ptr_reg;
  owner_t     rd_owner_reg;
  logic [3:0] starve_cnt_reg;
  owner_t     gnt_sel;
  logic       gnt_is_read;

  always_comb begin
    gnt_sel = OWN_NONE;
    if (!rst_async) begin
      if (bus.gpu_req && bus.gpu_urgent) begin
        gnt_sel = OWN_GPU;
      end else if (bus.fetch_req && (starve_cnt_reg == MAX_WAIT_C)) begin
        gnt_sel = OWN_FETCH;
      end else begin
        case (rr_ptr_reg)
          OWN_FETCH: begin
            if (bus.lsu_req)        gnt_sel = OWN_LSU;
            else if (bus.gpu_req)   gnt_sel = OWN_GPU;
            else if (bus.fetch_req) gnt_sel = OWN_FETCH;
          end
          OWN_LSU: begin
            if (bus.gpu_req)        gnt_sel = OWN_GPU;
            else if (bus.fetch_req) gnt_sel = OWN_FETCH;
            else if (bus.lsu_req)   gnt_sel = OWN_LSU;
          end
          default: begin
            if (bus.fetch_req)      gnt_sel = OWN_FETCH;
            else if (bus.lsu_req)   gnt_sel = OWN_LSU;
            else if (bus.gpu_req)   gnt_sel = OWN_GPU;
          end
        endcase
      end
    end
  end

  assign bus.fetch_gnt = (gnt_sel == OWN_FETCH);
  assign bus.lsu_gnt   = (gnt_sel == OWN_LSU);
  assign bus.gpu_gnt   = (gnt_sel == OWN_GPU);
  assign gnt_is_read   = (gnt_sel != OWN_NONE) && !((gnt_sel == OWN_LSU) && bus.lsu_we);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 2'b00;
    bus.mem_wdata = '0;
    case (gnt_sel)
      OWN_FETCH: begin
        bus.mem_addr = bus.fetch_addr;
        bus.mem_be   = 2'b11;
      end
      OWN_LSU: begin
        bus.mem_addr  = bus.lsu_addr;
        bus.mem_we    = bus.lsu_we;
        bus.mem_be    = bus.lsu_we ? bus.lsu_be : 2'b11;
        bus.mem_wdata = bus.lsu_wdata;
      end
      OWN_GPU: begin
        bus.mem_addr = bus.gpu_addr;
        bus.mem_be   = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rr_ptr_reg     <= OWN_GPU;
      rd_owner_reg   <= OWN_NONE;
      starve_cnt_reg <= 4'd0;
    end else begin
      if (gnt_sel != OWN_NONE) begin
        rr_ptr_reg <= gnt_sel;
      end
      rd_owner_reg <= gnt_is_read ? gnt_sel : OWN_NONE;
      if (bus.fetch_req && (gnt_sel != OWN_FETCH)) begin
        if (starve_cnt_reg != MAX_WAIT_C) begin
          starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
      end else begin
        starve_cnt_reg <= 4'd0;
      end
    end
  end

  // Read data is a plain passthrough; only the owner's rvalid qualifies it.
  assign bus.fetch_rvalid = (rd_owner_reg == OWN_FETCH);
  assign bus.lsu_rvalid   = (rd_owner_reg == OWN_LSU);
  assign bus.gpu_rvalid   = (rd_owner_reg == OWN_GPU);
  assign bus.fetch_rdata  = bus.mem_rdata;
  assign bus.lsu_rdata    = bus.mem_rdata;
  assign bus.gpu_rdata    = bus.mem_rdata;
endmodule
